// File: rtl/lsp_pkg.sv
// Shared constants, state encoding and the freq_prev/fg row-address helper for
// the LSP predictor-history extract block.
package lsp_pkg;

  localparam int M     = 10;
  localparam int MA_NP = 4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_LSP = 4'd1,
    S_LD_LSP = 4'd2,
    S_RD_FP  = 4'd3,
    S_RD_FG  = 4'd4,
    S_MSU    = 4'd5,
    S_RD_INV = 4'd6,
    S_MULT   = 4'd7,
    S_WRITE  = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  // Row k, column j of a [MA_NP][M] table whose base is 64-word aligned.
  function automatic logic [11:0] row_addr(input logic [11:0] base,
                                           input logic [1:0]  k,
                                           input logic [3:0]  j);
    return {1'b0, base[10:6], k, j};
  endfunction

endpackage

// File: rtl/lsp_shl3_sat.sv
// Saturating left shift by 3 of a signed 32-bit value; sat flags a clipped result.
module lsp_shl3_sat (
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        sat
);

  logic pos_ovf;
  logic neg_ovf;

  // The shift is lossless only while bits [31:28] are all equal to the sign.
  always_comb begin
    pos_ovf = ~din[31] & (|din[30:28]);
    neg_ovf = din[31] & ~(&din[30:28]);
    sat     = pos_ovf | neg_ovf;
    if (pos_ovf)      dout = 32'h7FFF_FFFF;
    else if (neg_ovf) dout = 32'h8000_0000;
    else              dout = {din[28:0], 3'b000};
  end

endmodule

// File: rtl/lsp_prev_extract.sv
// Rebuilds lsp_ele[j] from lsp[], the MA predictor history freq_prev/fg and fg_sum_inv,
// using the shared L_msu/L_mult units. Optional sticky saturation flag: LSP_EXTRACT_OVF_EN.
module lsp_prev_extract
  import lsp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] lspAddr,
  input  logic [11:0] lsp_eleAddr,
  input  logic [11:0] freq_prevAddr,
  input  logic [11:0] fgAddr,
  input  logic [11:0] fg_sum_invAddr,
  input  logic [31:0] memIn,
  input  logic [31:0] L_msuIn,
  input  logic [31:0] L_multIn,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic [31:0] L_msuOutA,
  output logic [15:0] L_msuOutB,
  output logic [15:0] L_msuOutC,
  output logic [15:0] L_multOutA,
  output logic [15:0] L_multOutB,
  output logic        done
`ifdef LSP_EXTRACT_OVF_EN
  ,
  output logic        ovf
`endif
);

  state_e      state_q, state_d;
  logic [3:0]  j_q, j_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] fp_q, fp_d;
  logic [31:0] prod_q, prod_d;

  logic [31:0] shl_res;
  logic        shl_sat;
  logic [15:0] res_h;

  lsp_shl3_sat u_shl3 (
    .din  (prod_q),
    .dout (shl_res),
    .sat  (shl_sat)
  );

  assign res_h = shl_res[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      fp_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      fp_q    <= fp_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    k_d          = k_q;
    acc_d        = acc_q;
    fp_d         = fp_q;
    prod_d       = prod_q;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    L_msuOutA    = '0;
    L_msuOutB    = '0;
    L_msuOutC    = '0;
    L_multOutA   = '0;
    L_multOutB   = '0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_LSP;
          j_d     = '0;
        end
      end
      S_RD_LSP: begin
        memReadAddr = lspAddr + {8'h00, j_q};
        state_d     = S_LD_LSP;
      end
      S_LD_LSP: begin
        acc_d   = {memIn[15:0], 16'h0000};
        k_d     = '0;
        state_d = S_RD_FP;
      end
      S_RD_FP: begin
        memReadAddr = row_addr(freq_prevAddr, k_q, j_q);
        state_d     = S_RD_FG;
      end
      S_RD_FG: begin
        fp_d        = memIn[15:0];
        memReadAddr = row_addr(fgAddr, k_q, j_q);
        state_d     = S_MSU;
      end
      S_MSU: begin
        // memIn carries fg here, read in RD_FG.
        L_msuOutA = acc_q;
        L_msuOutB = fp_q;
        L_msuOutC = memIn[15:0];
        acc_d     = L_msuIn;
        if (k_q != 2'(MA_NP - 1)) begin
          k_d     = k_q + 2'd1;
          state_d = S_RD_FP;
        end else begin
          state_d = S_RD_INV;
        end
      end
      S_RD_INV: begin
        memReadAddr = fg_sum_invAddr + {8'h00, j_q};
        state_d     = S_MULT;
      end
      S_MULT: begin
        L_multOutA = acc_q[31:16];
        L_multOutB = memIn[15:0];
        prod_d     = L_multIn;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        memWriteAddr = lsp_eleAddr + {8'h00, j_q};
        memOut       = {{16{res_h[15]}}, res_h};
        memWriteEn   = 1'b1;
        if (j_q != 4'(M - 1)) begin
          j_d     = j_q + 4'd1;
          state_d = S_RD_LSP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LSP_EXTRACT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_IDLE && start)
      ovf_d = 1'b0;
    else if (state_q == S_WRITE && shl_sat)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  logic unused_bits;
  assign unused_bits = ^{memIn[31:16], freq_prevAddr[11], freq_prevAddr[5:0],
                         fgAddr[11], fgAddr[5:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{memIn[31:16], freq_prevAddr[11], freq_prevAddr[5:0],
                         fgAddr[11], fgAddr[5:0], shl_sat};
`endif

endmodule

// File: tb/tb_lsp_prev_extract.sv
// Directed + random bench for lsp_prev_extract: memory, L_msu and L_mult are modelled here,
// lsp_ele results are compared against an arithmetic reference of the basic-op formula.
module tb_lsp_prev_extract;

  localparam logic [11:0] LSP_BASE = 12'h200;
  localparam logic [11:0] ELE_BASE = 12'h300;
  localparam logic [11:0] FP_BASE  = 12'h040;
  localparam logic [11:0] FG_BASE  = 12'h100;
  localparam logic [11:0] INV_BASE = 12'h220;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] memIn, L_msuIn, L_multIn;
  logic [11:0] memReadAddr, memWriteAddr;
  logic [31:0] memOut, L_msuOutA;
  logic        memWriteEn, done;
  logic [15:0] L_msuOutB, L_msuOutC, L_multOutA, L_multOutB;
  logic        ovf;

  always #5 clk = ~clk;

  lsp_prev_extract dut (
    .clk(clk), .reset(reset), .start(start),
    .lspAddr(LSP_BASE), .lsp_eleAddr(ELE_BASE), .freq_prevAddr(FP_BASE),
    .fgAddr(FG_BASE), .fg_sum_invAddr(INV_BASE),
    .memIn(memIn), .L_msuIn(L_msuIn), .L_multIn(L_multIn),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
    .memWriteEn(memWriteEn), .L_msuOutA(L_msuOutA), .L_msuOutB(L_msuOutB),
    .L_msuOutC(L_msuOutC), .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
    .done(done)
`ifdef LSP_EXTRACT_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef LSP_EXTRACT_OVF_EN
  assign ovf = 1'b0;
`endif

  // ---------------- basic-op models (the shared external units) ----------------
  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648) return 32'h8000_0000;
    else                           return v[31:0];
  endfunction

  function automatic logic [31:0] f_mult(input logic [15:0] a, input logic [15:0] b);
    return sat32(longint'($signed(a)) * longint'($signed(b)) * 2);
  endfunction

  function automatic logic [31:0] f_msu(input logic [31:0] acc, input logic [15:0] a,
                                       input logic [15:0] b);
    return sat32(longint'($signed(acc)) - longint'($signed(f_mult(a, b))));
  endfunction

  always_comb L_msuIn  = f_msu(L_msuOutA, L_msuOutB, L_msuOutC);
  always_comb L_multIn = f_mult(L_multOutA, L_multOutB);

  // ---------------- memory with 1-cycle read latency and a bench load port ----------------
  logic [31:0] mem [0:4095];
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (memWriteEn) begin
      mem[memWriteAddr] <= memOut;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- stimulus tables and reference ----------------
  logic [15:0] lsp_v [10];
  logic [15:0] inv_v [10];
  logic [15:0] fp_v  [4][10];
  logic [15:0] fg_v  [4][10];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_ele(input int j, output logic s);
    longint acc, t, p, x;
    acc = longint'($signed(lsp_v[j])) * 65536;
    for (int k = 0; k < 4; k++)
      acc = longint'($signed(f_msu(acc[31:0], fp_v[k][j], fg_v[k][j])));
    t = acc >>> 16;
    p = longint'($signed(f_mult(t[15:0], inv_v[j])));
    x = p * 8;
    s = (x > 64'sd2147483647) || (x < -64'sd2147483648);
    if (x > 64'sd2147483647)       x = 64'sd2147483647;
    else if (x < -64'sd2147483648) x = -64'sd2147483648;
    return x[31:16];
  endfunction

  task automatic fill(input logic [15:0] lsp, input logic [15:0] fp, input logic [15:0] fg,
                      input logic [15:0] inv);
    for (int j = 0; j < 10; j++) begin
      lsp_v[j] = lsp;
      inv_v[j] = inv;
      for (int k = 0; k < 4; k++) begin
        fp_v[k][j] = fp;
        fg_v[k][j] = fg;
      end
    end
  endtask

  task automatic ld(input logic [11:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = {{16{v[15]}}, v};
  endtask

  task automatic load_all();
    for (int j = 0; j < 10; j++) begin
      ld(LSP_BASE + 12'(j), lsp_v[j]);
      ld(INV_BASE + 12'(j), inv_v[j]);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = ELE_BASE + 12'(j); ld_data = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) begin
        ld(FP_BASE + 12'(16 * k + j), fp_v[k][j]);
        ld(FG_BASE + 12'(16 * k + j), fg_v[k][j]);
      end
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Start one run, wait for done, check latency, write count and every lsp_ele.
  task automatic run_check(input string tag);
    int cyc, wr0;
    logic s, any_s;
    logic [15:0] e;
    wr0 = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, cyc, 171);
    chk({tag, "_writes"}, wr_cnt - wr0, 10);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    any_s = 1'b0;
    for (int j = 0; j < 10; j++) begin
      e = ref_ele(j, s);
      any_s |= s;
      chk($sformatf("%s_ele%0d", tag, j), mem[ELE_BASE + 12'(j)], {{16{e[15]}}, e});
    end
`ifdef LSP_EXTRACT_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(any_s));
`endif
  endtask

  initial begin
    int cyc, wr0, nd;
    int dcyc [2];
    int dwr [2];
    reset = 1'b0; start = 1'b0;
    #1;
    chk("rst_rdaddr", 32'(memReadAddr), 0);
    chk("rst_wen", 32'(memWriteEn), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_msuA", L_msuOutA, 0);
    chk("rst_ovf", 32'(ovf), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // identity, predictor, row decode, saturation
    fill(16'd1000, 16'd0, 16'd0, 16'd4096);          load_all(); run_check("ident");
    chk("ident_val", mem[ELE_BASE + 12'd3], 32'd1000);
    fill(16'd1000, 16'd100, 16'd8192, 16'd4096);     load_all(); run_check("pred");
    chk("pred_val", mem[ELE_BASE + 12'd9], 32'd900);
    fill(16'd0, 16'd0, 16'd0, 16'd4096);
    for (int j = 0; j < 10; j++) begin fp_v[2][j] = 16'd1; fg_v[2][j] = 16'd32767; end
    load_all(); run_check("rowdec");
    chk("rowdec_val", mem[ELE_BASE + 12'd5], 32'hFFFF_FFFF);
    fill(16'd32767, 16'd0, 16'd0, 16'd32767);        load_all(); run_check("sat");
    chk("sat_val", mem[ELE_BASE], 32'h0000_7FFF);
    @(posedge clk); #1;
    chk("sat_idle_wen", 32'(memWriteEn), 0);

    // reset mid-run at cycle 50
    fill(16'd1000, 16'd0, 16'd0, 16'd4096); load_all();
    wr0 = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 2; c <= 50; c++) begin @(posedge clk); #1; end
    reset = 1'b0; #1;
    chk("midrst_rdaddr", 32'(memReadAddr), 0);
    chk("midrst_msuA", L_msuOutA, 0);
    chk("midrst_multA", 32'(L_multOutA), 0);
    nd = 0;
    repeat (5) begin @(posedge clk); #1; if (done || memWriteEn) nd++; end
    chk("midrst_quiet", nd, 0);
    chk("midrst_writes", wr_cnt - wr0, 2);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("midrst_idle_writes", wr_cnt - wr0, 2);
    load_all(); run_check("restart");

    // start held high: done at 171 and 343 only
    wr0 = wr_cnt; nd = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) begin
        if (nd < 2) begin dcyc[nd] = c; dwr[nd] = wr_cnt - wr0; end
        nd++;
      end
    end
    start = 1'b0;
    chk("held_npulses", nd, 2);
    chk("held_done0", dcyc[0], 171);
    chk("held_done1", dcyc[1], 343);
    chk("held_wr0", dwr[0], 10);
    chk("held_wr1", dwr[1], 20);
    cyc = 0;
    while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("held_drain", 32'(done), 32'd1);
    @(posedge clk); #1;

    // random patterns
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 10; j++) begin
        lsp_v[j] = 16'($urandom_range(0, 65535));
        inv_v[j] = 16'($urandom_range(0, 65535));
        for (int k = 0; k < 4; k++) begin
          fp_v[k][j] = 16'($urandom_range(0, 65535));
          fg_v[k][j] = 16'($urandom_range(0, 65535));
        end
      end
      load_all();
      run_check($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
